// File: rtl/imem_loader.sv
// Instruction-memory loader: frames a header/count/data/checksum byte stream into
// big-endian 32-bit words. It holds the CPU until a frame loads with a matching checksum.
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [8:0] DepthMax = 9'(DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        frameLen_q, frameLen_d;
  logic [7:0]        wordsLoaded_q, wordsLoaded_d;
  logic [7:0]        checksum_q, checksum_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [23:0]       partWord_q, partWord_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [31:0]       memDin_q, memDin_d;
  logic              accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      frameLen_q    <= '0;
      wordsLoaded_q <= '0;
      checksum_q    <= '0;
      byteIdx_q     <= '0;
      partWord_q    <= '0;
      memWe_q       <= 1'b0;
      memAddr_q     <= '0;
      memDin_q      <= '0;
    end else begin
      state_q       <= state_d;
      frameLen_q    <= frameLen_d;
      wordsLoaded_q <= wordsLoaded_d;
      checksum_q    <= checksum_d;
      byteIdx_q     <= byteIdx_d;
      partWord_q    <= partWord_d;
      memWe_q       <= memWe_d;
      memAddr_q     <= memAddr_d;
      memDin_q      <= memDin_d;
    end
  end

  // start overrides everything, including a byte offered in the same cycle
  always_comb begin
    state_d       = state_q;
    frameLen_d    = frameLen_q;
    wordsLoaded_d = wordsLoaded_q;
    checksum_d    = checksum_q;
    byteIdx_d     = byteIdx_q;
    partWord_d    = partWord_q;
    memWe_d       = 1'b0;
    memAddr_d     = memAddr_q;
    memDin_d      = memDin_q;
    rx_ready      = 1'b0;
    accept        = 1'b0;

    if (start) begin
      if (state_q != S_IDLE) begin
        state_d   = S_IDLE;
        byteIdx_d = '0;
      end
    end else begin
      rx_ready = (state_q == S_IDLE) || (state_q == S_COUNT) ||
                 (state_q == S_DATA) || (state_q == S_CHECK);
      accept   = rx_ready && rx_valid;

      if (accept) begin
        unique case (state_q)
          S_IDLE: begin
            if (rx_data == HEADER) begin
              state_d       = S_COUNT;
              checksum_d    = '0;
              wordsLoaded_d = '0;
              byteIdx_d     = '0;
            end
          end
          S_COUNT: begin
            if ((rx_data == 8'd0) || ({1'b0, rx_data} > DepthMax)) begin
              state_d = S_ERR;
            end else begin
              frameLen_d = rx_data;
              state_d    = S_DATA;
            end
          end
          S_DATA: begin
            partWord_d = {partWord_q[15:0], rx_data};
            checksum_d = checksum_q ^ rx_data;
            byteIdx_d  = byteIdx_q + 2'd1;
            if (byteIdx_q == 2'd3) begin
              memWe_d       = 1'b1;
              memDin_d      = {partWord_q, rx_data};
              memAddr_d     = ADDR_W'(wordsLoaded_q);
              wordsLoaded_d = wordsLoaded_q + 8'd1;
              if (wordsLoaded_d == frameLen_q) begin
                state_d = S_CHECK;
              end
            end
          end
          S_CHECK: begin
            state_d = (rx_data == checksum_q) ? S_DONE : S_ERR;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign mem_we       = memWe_q;
  assign mem_addr     = memAddr_q;
  assign mem_din      = memDin_q;
  assign words_loaded = wordsLoaded_q;
  assign load_done    = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);
  assign cpu_hold     = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model builds byte streams
// and the expected write list, a monitor collects the writes the DUT actually issues.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 8;
  localparam logic [7:0]  HEADER = 8'hA5;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [7:0]        words_loaded;

  int errors;
  int checks;

  logic [7:0]  txQ[$];
  logic [39:0] expQ[$];
  logic [39:0] obsQ[$];
  bit          expOk;
  int          expWords;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HEADER(HEADER)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .start(start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every write strobe the DUT issues
  always @(negedge clk) begin
    if (mem_we) obsQ.push_back({mem_addr, mem_din});
  end

  task automatic checkOutput(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".rx_ready"}, rx_ready, 1);
    checkOutput({tag, ".mem_we"}, mem_we, 0);
    checkOutput({tag, ".mem_addr"}, mem_addr, 0);
    checkOutput({tag, ".mem_din"}, mem_din, 0);
    checkOutput({tag, ".cpu_hold"}, cpu_hold, 1);
    checkOutput({tag, ".load_done"}, load_done, 0);
    checkOutput({tag, ".load_err"}, load_err, 0);
    checkOutput({tag, ".words"}, words_loaded, 0);
  endtask

  // Offer one byte, idling gap cycles first; returns 1ns after the negedge following transfer
  task automatic sendByte(input logic [7:0] b, input int gap);
    bit accepted;
    int tries;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    tries    = 0;
    accepted = 1'b0;
    while (!accepted) begin
      #1;
      accepted = rx_ready;
      @(posedge clk);
      @(negedge clk);
      #1;
      tries++;
      if (!accepted && tries > 50) begin
        checkOutput("sendTimeout", 0, 1);
        accepted = 1'b1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int gap, input int nBytes);
    int limit;
    limit = (nBytes < 0) ? txQ.size() : nBytes;
    for (int i = 0; i < limit; i++) sendByte(txQ[i], gap);
  endtask

  task automatic pulseStart(input bit withValid);
    @(negedge clk);
    start    = 1'b1;
    rx_valid = withValid;
    rx_data  = HEADER;
    #1;
    if (withValid) checkOutput("startBlocksReady", rx_ready, 0);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    #1;
    checkOutput("afterStart.hold", cpu_hold, 1);
    checkOutput("afterStart.done", load_done, 0);
    checkOutput("afterStart.err", load_err, 0);
    checkOutput("afterStart.ready", rx_ready, 1);
  endtask

  task automatic clearFrame();
    txQ.delete();
    expQ.delete();
    obsQ.delete();
  endtask

  // Reference model: frame bytes, expected writes and outcome from the frame format rules
  task automatic buildFrame(input int n, input bit badChk);
    logic [7:0]  chk;
    logic [31:0] w;
    chk = 8'h00;
    txQ.push_back(HEADER);
    txQ.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      expQ.push_back({8'(i), w});
      for (int k = 3; k >= 0; k--) begin
        txQ.push_back(w[k*8 +: 8]);
        chk = chk ^ w[k*8 +: 8];
      end
    end
    if (badChk) chk = chk ^ 8'(1 + $urandom_range(0, 254));
    txQ.push_back(chk);
    expOk    = !badChk;
    expWords = n;
  endtask

  task automatic checkWrites(input string tag);
    @(negedge clk);
    #1;
    checkOutput({tag, ".nWrites"}, 40'(obsQ.size()), 40'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      checkOutput($sformatf("%s.write%0d", tag, i), obsQ[i], expQ[i]);
  endtask

  task automatic checkFrame(input string tag);
    checkWrites(tag);
    checkOutput({tag, ".done"}, load_done, 40'(expOk));
    checkOutput({tag, ".err"}, load_err, 40'(!expOk));
    checkOutput({tag, ".hold"}, cpu_hold, 40'(!expOk));
    checkOutput({tag, ".ready"}, rx_ready, 0);
    checkOutput({tag, ".words"}, words_loaded, 40'(expWords));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    doReset(2);
    checkReset("reset");

    // Single-word frame with hand-computed checksum
    clearFrame();
    sendByte(HEADER, 0);
    sendByte(8'h01, 0);
    sendByte(8'h12, 0);
    sendByte(8'h34, 0);
    sendByte(8'h56, 0);
    checkOutput("t1.noEarlyWe", mem_we, 0);
    sendByte(8'h78, 0);
    checkOutput("t1.we", mem_we, 1);
    checkOutput("t1.addr", mem_addr, 0);
    checkOutput("t1.din", mem_din, 40'h12345678);
    sendByte(8'h08, 0);
    checkOutput("t1.weSingle", mem_we, 0);
    checkOutput("t1.done", load_done, 1);
    checkOutput("t1.hold", cpu_hold, 0);
    checkOutput("t1.err", load_err, 0);
    checkOutput("t1.ready", rx_ready, 0);
    checkOutput("t1.words", words_loaded, 1);
    expQ.push_back({8'h00, 32'h12345678});
    checkWrites("t1");
    pulseStart(1'b1);

    // Junk before header is dropped
    clearFrame();
    txQ.push_back(8'h00);
    txQ.push_back(8'hFF);
    txQ.push_back(8'h5A);
    buildFrame(2, 1'b0);
    applyStimulus(0, -1);
    checkFrame("t2");
    pulseStart(1'b0);

    // Wrong checksum: all words still written, then error
    clearFrame();
    buildFrame(3, 1'b1);
    applyStimulus(0, -1);
    checkFrame("t3");
    pulseStart(1'b0);

    // Count byte out of range on both ends
    clearFrame();
    sendByte(HEADER, 0);
    sendByte(8'h00, 0);
    checkOutput("t4a.err", load_err, 1);
    checkOutput("t4a.hold", cpu_hold, 1);
    checkOutput("t4a.ready", rx_ready, 0);
    checkWrites("t4a");
    pulseStart(1'b0);
    clearFrame();
    sendByte(HEADER, 0);
    sendByte(8'(DEPTH + 1), 0);
    checkOutput("t4b.err", load_err, 1);
    checkOutput("t4b.done", load_done, 0);
    checkWrites("t4b");
    pulseStart(1'b0);

    // Abort after six data bytes, then a clean frame
    clearFrame();
    buildFrame(3, 1'b0);
    applyStimulus(0, 8);
    pulseStart(1'b1);
    while (expQ.size() > 1) void'(expQ.pop_back());
    checkWrites("t5abort");
    clearFrame();
    buildFrame(2, 1'b0);
    applyStimulus(0, -1);
    checkFrame("t5reload");
    pulseStart(1'b0);

    // Full-depth frame with valid present one cycle in three
    clearFrame();
    buildFrame(DEPTH, 1'b0);
    applyStimulus(2, -1);
    checkFrame("t6depth");
    pulseStart(1'b0);

    // Reset arriving together with the 4th data byte: no write may follow
    clearFrame();
    buildFrame(3, 1'b0);
    applyStimulus(0, 5);
    rx_data  = txQ[5];
    rx_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    checkReset("t6rst");
    @(negedge clk);
    #1;
    checkOutput("t6rst.weAfter", mem_we, 0);
    checkOutput("t6rst.nWrites", 40'(obsQ.size()), 0);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      logic [7:0] j;
      clearFrame();
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom);
        if (j == HEADER) j = 8'h00;
        txQ.push_back(j);
      end
      buildFrame(int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0));
      applyStimulus(int'($urandom_range(0, 2)), -1);
      checkFrame($sformatf("rand%0d", f));
      pulseStart(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
